// File: rtl/rt_ibex_hws_inject_port.sv
// ID-stage injection port: merges stacker-injected instructions into the IF->ID stream,
// parking one fetched instruction during a sequence. Define RT_IBEX_HWS_INJECT_CHECK_EN for the count check.
module rt_ibex_hws_inject_port #(
  parameter int unsigned HwsInstrCount = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_instr_valid_i,
  input  logic [31:0] if_instr_rdata_i,
  input  logic        if_instr_is_compressed_i,
  output logic        if_instr_ready_o,
  input  logic        hws_instr_valid_i,
  input  logic [31:0] hws_instr_rdata_i,
  input  logic        hws_done_i,
  output logic        hws_in_ready_o,
  output logic        hws_ack_o,
  input  logic        flush_i,
  input  logic        id_ready_i,
  output logic        id_instr_valid_o,
  output logic [31:0] id_instr_rdata_o,
  output logic        id_instr_is_compressed_o,
  output logic        id_instr_is_hws_o,
  output logic        count_err_o
);

  typedef enum logic [1:0] {IDLE, INJECT, ACK, REPLAY} state_e;

  state_e      state_q, state_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_rdata_q, hold_rdata_d;
  logic        hold_c_q, hold_c_d;

  logic        cnt_clear, cnt_inc, cnt_check;
  logic        id_valid, id_c, id_hws, if_ready, hws_ready, ack;
  logic [31:0] id_rdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  // NOTE: the hold payload is deliberately not reset; it is only ever observed qualified by hold_valid_q.
  always_ff @(posedge clk_i) begin
    hold_rdata_q <= hold_rdata_d;
    hold_c_q     <= hold_c_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_rdata_d = hold_rdata_q;
    hold_c_d     = hold_c_q;
    id_valid     = 1'b0;
    id_rdata     = 32'h0;
    id_c         = 1'b0;
    id_hws       = 1'b0;
    if_ready     = 1'b0;
    hws_ready    = 1'b0;
    ack          = 1'b0;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    cnt_check    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hws_instr_valid_i && !flush_i) begin
          // Injection wins; a fetch arriving in the same cycle is parked for replay.
          id_valid  = 1'b1;
          id_rdata  = hws_instr_rdata_i;
          id_hws    = 1'b1;
          hws_ready = id_ready_i;
          cnt_clear = 1'b1;
          cnt_inc   = id_ready_i;
          state_d   = INJECT;
          if (if_instr_valid_i) begin
            hold_valid_d = 1'b1;
            hold_rdata_d = if_instr_rdata_i;
            hold_c_d     = if_instr_is_compressed_i;
            if_ready     = 1'b1;
          end
        end else begin
          id_valid = if_instr_valid_i;
          id_rdata = if_instr_rdata_i;
          id_c     = if_instr_is_compressed_i;
          if_ready = id_ready_i;
          if (flush_i) hold_valid_d = 1'b0;
        end
      end
      INJECT: begin
        // Flush is ignored here: a stacking sequence is atomic.
        id_valid  = hws_instr_valid_i;
        id_rdata  = hws_instr_rdata_i;
        id_hws    = 1'b1;
        hws_ready = hws_instr_valid_i & id_ready_i;
        cnt_inc   = hws_ready;
        if (hws_done_i && !hws_instr_valid_i) state_d = ACK;
      end
      ACK: begin
        ack       = 1'b1;
        cnt_check = 1'b1;
        state_d   = hold_valid_q ? REPLAY : IDLE;
      end
      REPLAY: begin
        id_valid = hold_valid_q;
        id_rdata = hold_rdata_q;
        id_c     = hold_c_q;
        if (flush_i || id_ready_i) begin
          hold_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RT_IBEX_HWS_INJECT_CHECK_EN
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (cnt_clear) begin
      cnt_d = {3'b000, cnt_inc};
      err_d = 1'b0;
    end else if (cnt_inc && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (cnt_check && (32'(cnt_q) != HwsInstrCount)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'h0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign count_err_o = err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^{cnt_clear, cnt_inc, cnt_check, HwsInstrCount};
  assign count_err_o = 1'b0;
`endif

  // Outputs are forced low while reset is asserted, independent of the live inputs.
  assign id_instr_valid_o         = rst_ni & id_valid;
  assign id_instr_rdata_o         = {32{rst_ni}} & id_rdata;
  assign id_instr_is_compressed_o = rst_ni & id_c;
  assign id_instr_is_hws_o        = rst_ni & id_hws;
  assign if_instr_ready_o         = rst_ni & if_ready;
  assign hws_in_ready_o           = rst_ni & hws_ready;
  assign hws_ack_o                = rst_ni & ack;

endmodule

// File: tb/tb_rt_ibex_hws_inject_port.sv
// Directed bench for rt_ibex_hws_inject_port: a sequence-level model checked every cycle,
// plus literal expectations at key points.
module tb_rt_ibex_hws_inject_port;

`ifdef RT_IBEX_HWS_INJECT_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif
  localparam int N = 10;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_instr_valid_i, if_instr_is_compressed_i, if_instr_ready_o;
  logic [31:0] if_instr_rdata_i;
  logic        hws_instr_valid_i, hws_done_i, hws_in_ready_o, hws_ack_o;
  logic [31:0] hws_instr_rdata_i;
  logic        flush_i, id_ready_i;
  logic        id_instr_valid_o, id_instr_is_compressed_o, id_instr_is_hws_o, count_err_o;
  logic [31:0] id_instr_rdata_o;

  rt_ibex_hws_inject_port #(.HwsInstrCount(N)) dut (
    .clk_i                    (clk_i),
    .rst_ni                   (rst_ni),
    .if_instr_valid_i         (if_instr_valid_i),
    .if_instr_rdata_i         (if_instr_rdata_i),
    .if_instr_is_compressed_i (if_instr_is_compressed_i),
    .if_instr_ready_o         (if_instr_ready_o),
    .hws_instr_valid_i        (hws_instr_valid_i),
    .hws_instr_rdata_i        (hws_instr_rdata_i),
    .hws_done_i               (hws_done_i),
    .hws_in_ready_o           (hws_in_ready_o),
    .hws_ack_o                (hws_ack_o),
    .flush_i                  (flush_i),
    .id_ready_i               (id_ready_i),
    .id_instr_valid_o         (id_instr_valid_o),
    .id_instr_rdata_o         (id_instr_rdata_o),
    .id_instr_is_compressed_o (id_instr_is_compressed_o),
    .id_instr_is_hws_o        (id_instr_is_hws_o),
    .count_err_o              (count_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_fail = 0;

  // Sequence-level view of the port: is a stacker sequence open, is an ack owed,
  // is a parked fetch waiting, how many injections were taken, sticky error.
  bit          m_seq, m_ack_due, m_replay_due, m_err;
  int          m_taken;
  logic [32:0] m_held[$];

  int n_hws_rdy = 0, n_if_rdy = 0, n_ack = 0, n_bad_rdy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    logic        e_valid, e_hws, e_comp, e_ifr, e_hwsr, e_ack, e_err;
    logic [31:0] e_rdata;
    @(negedge clk_i);
    e_valid = 0; e_hws = 0; e_comp = 0; e_ifr = 0; e_hwsr = 0; e_ack = 0;
    e_rdata = 32'h0;
    e_err   = CheckEn ? m_err : 1'b0;
    if (!rst_ni) begin
      e_err = 1'b0;
      m_seq = 0; m_ack_due = 0; m_replay_due = 0; m_err = 0; m_taken = 0;
      m_held.delete();
      check("rst_rdata", id_instr_rdata_o, 32'h0);
    end else if (m_ack_due) begin
      e_ack     = 1'b1;
      m_ack_due = 0;
      if (m_taken != N) m_err = 1;
      m_replay_due = (m_held.size() > 0);
    end else if (m_replay_due) begin
      e_valid = 1'b1;
      e_rdata = m_held[0][31:0];
      e_comp  = m_held[0][32];
      if (flush_i || id_ready_i) begin
        void'(m_held.pop_front());
        m_replay_due = 0;
      end
    end else if (m_seq) begin
      e_valid = hws_instr_valid_i;
      e_rdata = hws_instr_rdata_i;
      e_hws   = 1'b1;
      e_hwsr  = hws_instr_valid_i & id_ready_i;
      if (e_hwsr) m_taken = (m_taken >= 15) ? 15 : m_taken + 1;
      if (hws_done_i && !hws_instr_valid_i) begin
        m_seq     = 0;
        m_ack_due = 1;
      end
    end else if (hws_instr_valid_i && !flush_i) begin
      e_valid = 1'b1;
      e_rdata = hws_instr_rdata_i;
      e_hws   = 1'b1;
      e_hwsr  = id_ready_i;
      e_ifr   = if_instr_valid_i;
      m_seq   = 1;
      m_err   = 0;
      m_taken = id_ready_i ? 1 : 0;
      if (if_instr_valid_i) m_held.push_back({if_instr_is_compressed_i, if_instr_rdata_i});
    end else begin
      e_valid = if_instr_valid_i;
      e_rdata = if_instr_rdata_i;
      e_comp  = if_instr_is_compressed_i;
      e_ifr   = id_ready_i;
      if (flush_i) m_held.delete();
    end
    check("id_valid", id_instr_valid_o, e_valid);
    check("if_ready", if_instr_ready_o, e_ifr);
    check("hws_in_ready", hws_in_ready_o, e_hwsr);
    check("hws_ack", hws_ack_o, e_ack);
    check("count_err", count_err_o, e_err);
    if (e_valid) begin
      check("id_rdata", id_instr_rdata_o, e_rdata);
      check("id_is_hws", id_instr_is_hws_o, e_hws);
      check("id_is_compressed", id_instr_is_compressed_o, e_comp);
    end
    if (rst_ni) begin
      n_hws_rdy += int'(hws_in_ready_o);
      n_if_rdy  += int'(if_instr_ready_o);
      n_ack     += int'(hws_ack_o);
      if (hws_in_ready_o && !id_ready_i) n_bad_rdy++;
    end
  endtask

  task automatic cyc();
    cmp_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Stacker emulation: n injections (optionally with id_ready toggling), then done until acked.
  task automatic run_seq(input int n, input bit bp, input bit flush_mid, input bit chk_clear,
                         input logic [31:0] next_if);
    int  i = 0;
    int  guard = 0;
    bit  phase = 1'b1;
    bit  acc;
    while (i < n && guard < 200) begin
      hws_instr_valid_i = 1'b1;
      hws_instr_rdata_i = 32'hA000_0000 + i;
      id_ready_i        = bp ? phase : 1'b1;
      flush_i           = flush_mid && (i > 0);
      acc               = id_ready_i;
      cyc();
      if (guard == 0) begin
        if (chk_clear) check("err_clear_on_start", count_err_o, 1'b0);
        if (if_instr_valid_i) if_instr_rdata_i = next_if;
      end
      phase = ~phase;
      if (acc) i++;
      guard++;
    end
    if (guard >= 200) check("seq_timeout", 1'b1, 1'b0);
    hws_instr_valid_i = 1'b0;
    hws_done_i        = 1'b1;
    id_ready_i        = 1'b1;
    flush_i           = flush_mid;
    cyc();
    check("ack_after_done", hws_ack_o, 1'b1);
    cyc();
    hws_done_i = 1'b0;
    flush_i    = 1'b0;
    check("ack_one_cycle", hws_ack_o, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0, a0;
    rst_ni = 1'b0;
    if_instr_valid_i = 0; if_instr_rdata_i = 0; if_instr_is_compressed_i = 0;
    hws_instr_valid_i = 0; hws_instr_rdata_i = 0; hws_done_i = 0;
    flush_i = 0; id_ready_i = 0;
    cyc();
    cyc();
    check("rst_id_valid", id_instr_valid_o, 1'b0);
    check("rst_count_err", count_err_o, 1'b0);
    rst_ni = 1'b1;

    // Idle pass-through, 32-bit then RVC with ID stalled.
    if_instr_valid_i = 1; if_instr_rdata_i = 32'h00A00513; id_ready_i = 1;
    #1;
    check("pass_rdata", id_instr_rdata_o, 32'h00A00513);
    check("pass_is_hws", id_instr_is_hws_o, 1'b0);
    check("pass_if_ready", if_instr_ready_o, 1'b1);
    cyc();
    if_instr_rdata_i = 32'h0000_4529; if_instr_is_compressed_i = 1; id_ready_i = 0;
    #1;
    check("pass_rvc", id_instr_is_compressed_o, 1'b1);
    check("pass_stall_if_ready", if_instr_ready_o, 1'b0);
    cyc();
    if_instr_valid_i = 0; if_instr_is_compressed_i = 0;
    cyc();

    // Save sequence without a pending fetch.
    p0 = n_hws_rdy; a0 = n_ack;
    run_seq(N, 0, 0, 0, 32'h0);
    check("save_ready_pulses", n_hws_rdy - p0, N);
    check("save_ack_pulses", n_ack - a0, 1);
    check("save_count_err", count_err_o, 1'b0);
    cyc();

    // Collision: fetch parked, replayed after the ack.
    if_instr_valid_i = 1; if_instr_rdata_i = 32'h00B505B3;
    f0 = n_if_rdy;
    run_seq(N, 0, 0, 0, 32'h00C00613);
    id_ready_i = 0;
    #1;
    check("replay_valid", id_instr_valid_o, 1'b1);
    check("replay_rdata", id_instr_rdata_o, 32'h00B505B3);
    check("replay_is_hws", id_instr_is_hws_o, 1'b0);
    cyc();
    id_ready_i = 1;
    cyc();
    check("collision_if_pulses", n_if_rdy - f0, 1);
    check("resume_rdata", id_instr_rdata_o, 32'h00C00613);
    if_instr_valid_i = 0;
    cyc();

    // Backpressure on ID during injection.
    p0 = n_hws_rdy;
    run_seq(N, 1, 0, 0, 32'h0);
    check("bp_ready_pulses", n_hws_rdy - p0, N);
    check("bp_ready_while_stalled", n_bad_rdy, 0);
    check("bp_count_err", count_err_o, 1'b0);
    cyc();

    // Short sequence, clearing sequence, saturating long sequence.
    run_seq(9, 0, 0, 0, 32'h0);
    check("short_count_err", count_err_o, CheckEn);
    cyc();
    run_seq(N, 0, 0, 1, 32'h0);
    check("clean_count_err", count_err_o, 1'b0);
    run_seq(17, 0, 0, 0, 32'h0);
    check("long_count_err", count_err_o, CheckEn);
    run_seq(N, 0, 0, 1, 32'h0);
    cyc();

    // Flush ignored during the sequence, honoured in REPLAY.
    if_instr_valid_i = 1; if_instr_rdata_i = 32'h00D00693;
    a0 = n_ack;
    run_seq(N, 0, 1, 0, 32'h00E00713);
    check("flush_seq_ack", n_ack - a0, 1);
    check("flush_seq_count_err", count_err_o, 1'b0);
    flush_i = 1; id_ready_i = 0; if_instr_valid_i = 0;
    #1;
    check("flush_replay_rdata", id_instr_rdata_o, 32'h00D00693);
    cyc();
    flush_i = 0;
    #1;
    check("flush_dropped_valid", id_instr_valid_o, 1'b0);
    cyc();
    cyc();

    // Asynchronous reset in the middle of an injection with a parked fetch.
    if_instr_valid_i = 1; if_instr_rdata_i = 32'h00F00793;
    hws_instr_valid_i = 1; hws_instr_rdata_i = 32'hA000_0000; id_ready_i = 1;
    cyc();
    if_instr_rdata_i = 32'h01000813;
    hws_instr_rdata_i = 32'hA000_0001;
    cyc();
    #2;
    rst_ni = 0;
    #1;
    check("rst_mid_valid", id_instr_valid_o, 1'b0);
    check("rst_mid_rdata", id_instr_rdata_o, 32'h0);
    check("rst_mid_is_hws", id_instr_is_hws_o, 1'b0);
    check("rst_mid_if_ready", if_instr_ready_o, 1'b0);
    check("rst_mid_hws_ready", hws_in_ready_o, 1'b0);
    check("rst_mid_ack", hws_ack_o, 1'b0);
    hws_instr_valid_i = 0;
    cyc();
    cyc();
    rst_ni = 1;
    if_instr_rdata_i = 32'h00A00513;
    #1;
    check("post_rst_rdata", id_instr_rdata_o, 32'h00A00513);
    check("post_rst_is_hws", id_instr_is_hws_o, 1'b0);
    cyc();
    if_instr_valid_i = 0;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rt_ibex_hws_inject_port.md
# rt_ibex_hws_inject_port

ID-stage injection port that consumes instructions produced by the RT-IBEX hardware stacking unit and merges them into the normal IF→ID instruction stream. It is the receiving end of the stacker's injection handshake: it returns `hws_in_ready_o` and acknowledges `hws_done_i` with `hws_ack_o`. It parks at most one fetched instruction while a save/restore sequence runs and replays it afterwards. Optionally, it checks that each sequence delivered the expected number of instructions.

## Interface
Parameters:
- `HwsInstrCount`, default 10: instructions per save or restore sequence. Save is alloc + 7 GPRs + MEPC + MCAUSE; restore is 7 GPRs + MEPC + MCAUSE + dealloc.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `if_instr_valid_i` in 1: fetched instruction valid.
- `if_instr_rdata_i` in 32: fetched instruction.
- `if_instr_is_compressed_i` in 1: fetched instruction is RVC.
- `if_instr_ready_o` out 1: fetched instruction consumed this cycle.
- `hws_instr_valid_i` in 1: stacker injected instruction valid. The stacker drives it from a register.
- `hws_instr_rdata_i` in 32: injected instruction, always 32-bit.
- `hws_done_i` in 1: stacker sequence complete. Held high until acked.
- `hws_in_ready_o` out 1: injected instruction accepted by ID this cycle.
- `hws_ack_o` out 1: one-cycle acknowledge of `hws_done_i`.
- `flush_i` in 1: controller flush.
- `id_ready_i` in 1: ID stage accepts the presented instruction.
- `id_instr_valid_o` out 1: instruction presented to ID.
- `id_instr_rdata_o` out 32: instruction presented to ID.
- `id_instr_is_compressed_o` out 1: presented instruction is RVC.
- `id_instr_is_hws_o` out 1: presented instruction is injected.
- `count_err_o` out 1: sticky count-mismatch flag.

## Operation
- FSM states: IDLE, INJECT, ACK, REPLAY. Reset state is IDLE.
- IDLE:
  - ID outputs mirror the IF inputs. `id_instr_is_hws_o`=0. `if_instr_ready_o`=`id_ready_i`.
  - When `hws_instr_valid_i`=1, the block goes to INJECT and the injected instruction is presented in the same cycle; injection has priority over fetch.
  - If `if_instr_valid_i`=1 in that same cycle and the fetched instruction is not otherwise consumed, it is captured into the hold buffer (`hold_valid`←1) and `if_instr_ready_o`=1.
  - The injection counter is cleared to 0 on entry to INJECT.
- INJECT:
  - ID outputs come from the `hws_*` inputs. `id_instr_is_compressed_o`=0. `id_instr_is_hws_o`=1. `if_instr_ready_o`=0.
  - `hws_in_ready_o` = `hws_instr_valid_i` & `id_ready_i`.
  - Each accepted injection increments the 4-bit counter, which saturates at 15.
  - When `hws_done_i`=1 and `hws_instr_valid_i`=0, the block goes to ACK. If both are 1, the instruction is accepted first and the done is taken in a later cycle.
- ACK:
  - `hws_ack_o`=1 for exactly one cycle. ID valid=0.
  - The count check runs here.
  - Next state is REPLAY if `hold_valid`, otherwise IDLE.
- REPLAY:
  - The hold buffer is presented to ID with `id_instr_is_hws_o`=0.
  - On `id_ready_i`, `hold_valid` clears and the block goes to IDLE. `if_instr_ready_o`=0 while in REPLAY.
- Flush:
  - In IDLE or REPLAY, `flush_i` clears `hold_valid` and forces IDLE.
  - In INJECT and ACK, `flush_i` is ignored; stacking sequences are atomic.
- Hold buffer: depth 1. A second fetched instruction is never accepted while `hold_valid`=1.

## Timing
- Reset values: all outputs 0, `hold_valid`=0, counter=0, `count_err_o`=0.
- Combinational paths: `hws_in_ready_o`, `if_instr_ready_o` and the ID outputs are combinational from state and inputs. There is no path from `hws_instr_valid_i` to `hws_in_ready_o` other than through the AND with `id_ready_i`.
- Injection latency: an injected instruction reaches ID in the same cycle it is valid. Sustained throughput is one instruction per cycle while `id_ready_i`=1.
- `hws_ack_o` asserts exactly one cycle after the cycle in which `hws_done_i` is seen in INJECT with no pending instruction. The stacker returns to its reset state on the following edge.
- Replay adds 1 cycle (ACK) plus ID acceptance latency before normal fetch resumes.
- Reset mid-sequence: asynchronous return to IDLE, and the held instruction is discarded. The stacker is reset by the same `rst_ni`.

## Configuration
- `RT_IBEX_HWS_INJECT_CHECK_EN` defined:
  - The counter is present.
  - In ACK, if counter ≠ `HwsInstrCount`, `count_err_o` is set.
  - `count_err_o` stays set until the next entry to INJECT or until reset.
- Undefined: the counter logic is removed and `count_err_o` is tied to 0. Functional behaviour is otherwise identical.

## Test plan
- Idle pass-through: IF presents 0x00A00513 with `id_ready_i`=1 → ID shows 0x00A00513, `id_instr_is_hws_o`=0, `if_instr_ready_o`=1.
- Save sequence, no pending fetch: 10 injected instructions back-to-back, then `hws_done_i` → 10 `hws_in_ready_o` pulses; `hws_ack_o` high exactly 1 cycle later; state returns to IDLE; `count_err_o`=0.
- Collision: `hws_instr_valid_i` and `if_instr_valid_i` (0x00B505B3) rise together → the injected instruction goes to ID first; after the ack, 0x00B505B3 is replayed with `is_hws`=0; only 1 `if_instr_ready_o` pulse in total.
- Backpressure: `id_ready_i` toggles 1/0 during injection → the counter ends at 10; no `hws_in_ready_o` pulse occurs while `id_ready_i`=0.
- Count error (macro defined): only 9 injections, then done → `count_err_o`=1 after ACK. It clears on the next sequence start. With the macro undefined, `count_err_o` stays 0.
- Flush and reset: `flush_i` in REPLAY → the held instruction is dropped and state is IDLE. `rst_ni` low mid-INJECT → all outputs 0 immediately.
